uart_echo_checker: RTL

Host-side loopback tester for the UART echo path. Drives the transmit side of a `uart` core instance with a deterministic byte pattern. Waits for each byte to come back on the receive side, compares it against the byte sent, and accumulates pass, error and timeout statistics. It sits opposite the board-side echo logic, on the far end of the serial link or in a loopback bench, and turns the echo design into a self-checking link test.

---
 rtl/uart_echo_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_echo_checker.sv
// Loopback tester: sends a byte pattern through a UART, checks each echo, and keeps pass/error/timeout counts.
// Define UART_CHK_LFSR_EN for an 8-bit LFSR pattern; otherwise the pattern is an incrementing byte.
module uart_echo_checker #(
   parameter int unsigned NUM_BYTES      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 110000,
   parameter logic [7:0]  SEED           = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        tx_empty,
   output logic [7:0]  tx_data,
   output logic        tx_load,
   input  logic        rx_data_ready,
   input  logic [7:0]  rx_data,
   output logic        rx_data_readed,
   output logic        busy,
   output logic        done,
   output logic [15:0] pass_count,
   output logic [15:0] err_count,
   output logic        timeout_seen,
   output logic [7:0]  last_expected,
   output logic [7:0]  last_received
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT_RX, S_CHECK, S_NEXT, S_DONE
   } state_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_BYTES - 1);
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [7:0]  pattern_q;
   logic [7:0]  pattern_d;
   logic [15:0] idx_q;
   logic [23:0] timer_q;
   logic [7:0]  tx_data_q;
   logic        tx_load_q;
   logic        rx_ack_q;
   logic        busy_q;
   logic        done_q;
   logic [15:0] pass_q;
   logic [15:0] err_q;
   logic [15:0] pass_inc_d;
   logic [15:0] err_inc_d;
   logic        tmo_q;
   logic [7:0]  last_exp_q;
   logic [7:0]  last_rx_q;

   always_comb begin
`ifdef UART_CHK_LFSR_EN
      pattern_d = {pattern_q[6:0], pattern_q[7] ^ pattern_q[5] ^ pattern_q[4] ^ pattern_q[3]};
`else
      pattern_d = pattern_q + 8'd1;
`endif
      pass_inc_d = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
      err_inc_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pattern_q  <= 8'h00;
         idx_q      <= 16'd0;
         timer_q    <= 24'd0;
         tx_data_q  <= 8'h00;
         tx_load_q  <= 1'b0;
         rx_ack_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 16'd0;
         err_q      <= 16'd0;
         tmo_q      <= 1'b0;
         last_exp_q <= 8'h00;
         last_rx_q  <= 8'h00;
      end else begin
         tx_load_q <= 1'b0;
         rx_ack_q  <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_SEND;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 16'd0;
                  err_q      <= 16'd0;
                  tmo_q      <= 1'b0;
                  last_exp_q <= 8'h00;
                  last_rx_q  <= 8'h00;
                  idx_q      <= 16'd0;
                  pattern_q  <= SEED;
                  tx_data_q  <= SEED;
                  tx_load_q  <= tx_empty;
               end else begin
                  // Drain stale echoes so they never reach a later run's count.
                  rx_ack_q <= rx_data_ready & ~rx_ack_q;
               end
            end
            S_SEND: begin
               // The load strobe is issued on the edge that enters or holds SEND,
               // so the SEND cycle carrying it hands over to WAIT_RX.
               if (tx_load_q) begin
                  state_q <= S_WAIT_RX;
                  timer_q <= 24'd0;
               end else if (tx_empty) begin
                  tx_load_q <= 1'b1;
                  tx_data_q <= pattern_q;
               end
            end
            S_WAIT_RX: begin
               if (rx_data_ready) begin
                  state_q  <= S_CHECK;
                  rx_ack_q <= 1'b1;
               end else if (timer_q == TMO_LAST) begin
                  err_q   <= err_inc_d;
                  tmo_q   <= 1'b1;
                  state_q <= S_NEXT;
               end else begin
                  timer_q <= timer_q + 24'd1;
               end
            end
            S_CHECK: begin
               last_exp_q <= pattern_q;
               last_rx_q  <= rx_data;
               if (rx_data == pattern_q) pass_q <= pass_inc_d;
               else                      err_q  <= err_inc_d;
               state_q <= S_NEXT;
            end
            S_NEXT: begin
               if (idx_q == LAST_IDX) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  pattern_q <= pattern_d;
                  idx_q     <= idx_q + 16'd1;
                  tx_data_q <= pattern_d;
                  tx_load_q <= tx_empty;
                  state_q   <= S_SEND;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_data        = tx_data_q;
   assign tx_load        = tx_load_q;
   assign rx_data_readed = rx_ack_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass_count     = pass_q;
   assign err_count      = err_q;
   assign timeout_seen   = tmo_q;
   assign last_expected  = last_exp_q;
   assign last_received  = last_rx_q;

endmodule
